alert_monitor: RTL
==================

Name: alert_monitor

Overview:
- Upstream stage of the piezo buzzer driver. Produces the three level flags `norm_mode`, `ovr_spd` and `batt_low` that the buzzer consumes.
- Flags are derived from the power-up state, periodic battery ADC samples and left/right motor duty samples.
- Applies debounce, hysteresis and hold-off so the buzzer never chatters on noisy samples.

Parameters:
- BATT_LOW_THRESH, 12'h800: battery code strictly below this counts as a "low" sample.
- BATT_HYST, 12'h040: clear level is BATT_LOW_THRESH+BATT_HYST (13-bit sum, no overflow).
- BATT_CNT, 4: consecutive qualifying samples needed to set or clear batt_low (range 1..15).
- OVR_SPD_THRESH, 11'd1536: duty magnitude strictly above this counts as overspeed.
- HOLD_CYCLES, 25_000_000: clk cycles ovr_spd is held after the last overspeed sample (0.5 s at 50 MHz).
- HOLD_W, 25: width of the hold counter; must satisfy 2^HOLD_W > HOLD_CYCLES.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- pwr_up  input  1  rider/power-up enable, level
- batt  input  12  unsigned battery ADC code
- batt_vld  input  1  one-cycle strobe: batt valid this cycle
- lft_duty  input  12  signed two's-complement left motor duty
- rght_duty  input  12  signed two's-complement right motor duty
- duty_vld  input  1  one-cycle strobe: both duties valid this cycle
- norm_mode  output  1  normal-operation flag
- ovr_spd  output  1  overspeed warning flag
- batt_low  output  1  low-battery warning flag

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- While rst=1: state=OFF, all counters 0; norm_mode=0, ovr_spd=0, batt_low=0. Reset asserted mid-operation clears everything immediately.
- All outputs are registered, with no combinational path from inputs.
- FSM has 2 states:
  - OFF: outputs 0, counters held at 0, strobes ignored. Goes to RUN on the cycle after pwr_up=1 is sampled.
  - RUN: norm_mode=1. pwr_up=0 sampled -> OFF next cycle; all flags and counters cleared in that same transition.
- batt_low, evaluated only in RUN on batt_vld=1:
  - Sample is "low" if batt < BATT_LOW_THRESH.
  - Sample is "ok" if batt >= BATT_LOW_THRESH+BATT_HYST.
  - Otherwise the sample is "band".
  - batt_low=0: low sample increments cnt, saturating at BATT_CNT. Ok or band sample zeroes cnt. batt_low sets on the cycle after the sample that brings cnt to BATT_CNT; cnt then zeroes.
  - batt_low=1: symmetric, using ok samples to count toward clear. Low or band sample zeroes cnt.
  - batt == BATT_LOW_THRESH exactly is band (not low).
  - batt_vld=0 leaves cnt unchanged.
- ovr_spd, evaluated only in RUN on duty_vld=1:
  - mag = |duty| as 12-bit unsigned; -2048 gives mag 2048.
  - Sample exceeds if mag(lft) > OVR_SPD_THRESH or mag(rght) > OVR_SPD_THRESH.
  - Exceed sample: ovr_spd=1 next cycle, and the hold counter loads HOLD_CYCLES.
  - Otherwise, while ovr_spd=1 the hold counter decrements once per clk (regardless of duty_vld). ovr_spd clears on the cycle after the counter reaches 0.
  - An exceed sample while held reloads the counter; no wrap below 0.
- batt_vld and duty_vld in the same cycle are processed independently, with no priority between them.
- Strobes arriving on the OFF->RUN transition cycle are ignored.
- Priority encoding of simultaneous flags is the buzzer's job. This block asserts each flag independently.

Test Plan:
- Use small parameters: BATT_CNT=4, HOLD_CYCLES=10, HOLD_W=4.
- Reset/power-up: rst=1 with pwr_up=1 -> all outputs 0. Release rst -> norm_mode=1 at 2nd clk edge; ovr_spd=0, batt_low=0.
- Battery debounce: 3 samples 12'h7FF, then 1 sample 12'h820 (band), then 4 samples 12'h7FF -> batt_low stays 0 until the cycle after the 4th consecutive low sample, then 1.
- Hysteresis clear: with batt_low=1, feed 4 samples 12'h83F -> batt_low stays 1. Feed 4 samples 12'h840 -> batt_low=0 the cycle after the 4th.
- Overspeed hold: lft_duty=-1537 on one strobe, then all strobes with duty 0 -> ovr_spd=1 next cycle, cleared exactly 11 cycles after the strobe. Repeat with rght_duty=1536 -> ovr_spd never sets. Repeat with -2048 -> ovr_spd sets.
- Reload/simultaneity: exceed strobe, then a second exceed strobe 5 cycles later alongside a batt_vld low sample -> hold restarts (clear 11 cycles after the 2nd strobe) and the batt counter advances.
- Mid-operation drop: with ovr_spd=1 and batt_low=1, pwr_up->0 -> all outputs 0 next cycle. pwr_up->1 -> norm_mode only; warnings must re-qualify from zero counts.

Source files
------------

// File: rtl/alert_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : alert_monitor
//  Description : Derives the three level flags consumed by the piezo buzzer
//                driver: norm_mode (powered up and running), ovr_spd (motor
//                duty overspeed, held for a fixed time after the last
//                overspeed sample) and batt_low (debounced, hysteretic
//                low-battery warning).
//
//  Ports       :
//    clk        in   1   system clock
//    rst        in   1   asynchronous active-high reset
//    pwr_up     in   1   rider/power-up enable (level)
//    batt       in  12   unsigned battery ADC code
//    batt_vld   in   1   one-cycle strobe, batt valid
//    lft_duty   in  12   signed left motor duty
//    rght_duty  in  12   signed right motor duty
//    duty_vld   in   1   one-cycle strobe, both duties valid
//    norm_mode  out  1   normal-operation flag (registered)
//    ovr_spd    out  1   overspeed warning flag (registered)
//    batt_low   out  1   low-battery warning flag (registered)
//
//  Revision    : 1.0  initial release
// ============================================================================
module alert_monitor #(
    parameter logic [11:0] BATT_LOW_THRESH = 12'h800,
    parameter logic [11:0] BATT_HYST       = 12'h040,
    parameter int unsigned BATT_CNT        = 4,
    parameter logic [10:0] OVR_SPD_THRESH  = 11'd1536,
    parameter int unsigned HOLD_CYCLES     = 25_000_000,
    parameter int unsigned HOLD_W          = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwr_up,
    input  logic [11:0] batt,
    input  logic        batt_vld,
    input  logic [11:0] lft_duty,
    input  logic [11:0] rght_duty,
    input  logic        duty_vld,
    output logic        norm_mode,
    output logic        ovr_spd,
    output logic        batt_low
);

    localparam logic [HOLD_W-1:0] C_HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
    localparam logic [3:0]        C_BATT_CNT  = 4'(BATT_CNT);
    // Clear level computed at 13 bits so threshold + hysteresis cannot wrap.
    localparam logic [12:0]       C_BATT_CLR  = {1'b0, BATT_LOW_THRESH} + {1'b0, BATT_HYST};

    typedef enum logic [0:0] {
        ST_OFF = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                norm_mode_q, norm_mode_d;
    logic                ovr_spd_q, ovr_spd_d;
    logic                batt_low_q, batt_low_d;
    logic [3:0]          batt_cnt_q, batt_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;

    logic [11:0] w_lft_mag;
    logic [11:0] w_rght_mag;
    logic        w_exceed;
    logic        w_batt_is_low;
    logic        w_batt_is_ok;
    logic        w_batt_qual;

    // Magnitude as 12-bit unsigned: -2048 negates to 12'h800, i.e. 2048.
    always_comb begin
        w_lft_mag  = lft_duty[11]  ? (~lft_duty  + 12'd1) : lft_duty;
        w_rght_mag = rght_duty[11] ? (~rght_duty + 12'd1) : rght_duty;
        w_exceed   = (w_lft_mag  > {1'b0, OVR_SPD_THRESH}) ||
                     (w_rght_mag > {1'b0, OVR_SPD_THRESH});
    end

    // A sample equal to the threshold falls in the band between low and ok.
    always_comb begin
        w_batt_is_low = (batt < BATT_LOW_THRESH);
        w_batt_is_ok  = ({1'b0, batt} >= C_BATT_CLR);
        // Samples that move the flag toward its opposite value.
        w_batt_qual   = batt_low_q ? w_batt_is_ok : w_batt_is_low;
    end

    always_comb begin
        state_d     = state_q;
        norm_mode_d = norm_mode_q;
        ovr_spd_d   = ovr_spd_q;
        batt_low_d  = batt_low_q;
        batt_cnt_d  = batt_cnt_q;
        hold_cnt_d  = hold_cnt_q;

        if (state_q == ST_OFF) begin
            norm_mode_d = 1'b0;
            ovr_spd_d   = 1'b0;
            batt_low_d  = 1'b0;
            batt_cnt_d  = 4'd0;
            hold_cnt_d  = '0;
            // Strobes in this cycle are ignored even when pwr_up is high.
            if (pwr_up) begin
                state_d     = ST_RUN;
                norm_mode_d = 1'b1;
            end
        end else if (!pwr_up) begin
            state_d     = ST_OFF;
            norm_mode_d = 1'b0;
            ovr_spd_d   = 1'b0;
            batt_low_d  = 1'b0;
            batt_cnt_d  = 4'd0;
            hold_cnt_d  = '0;
        end else begin
            norm_mode_d = 1'b1;

            // Battery debounce: consecutive qualifying samples toggle the flag;
            // any non-qualifying sample restarts the count.
            if (batt_vld) begin
                if (w_batt_qual) begin
                    if ((batt_cnt_q + 4'd1) == C_BATT_CNT) begin
                        batt_low_d = ~batt_low_q;
                        batt_cnt_d = 4'd0;
                    end else begin
                        batt_cnt_d = batt_cnt_q + 4'd1;
                    end
                end else begin
                    batt_cnt_d = 4'd0;
                end
            end

            // Overspeed hold: an exceed sample (re)loads the counter; otherwise
            // the held flag counts down every cycle and drops one cycle after 0.
            if (duty_vld && w_exceed) begin
                ovr_spd_d  = 1'b1;
                hold_cnt_d = C_HOLD_LOAD;
            end else if (ovr_spd_q) begin
                if (hold_cnt_q == '0) begin
                    ovr_spd_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_OFF;
            norm_mode_q <= 1'b0;
            ovr_spd_q   <= 1'b0;
            batt_low_q  <= 1'b0;
            batt_cnt_q  <= 4'd0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            norm_mode_q <= norm_mode_d;
            ovr_spd_q   <= ovr_spd_d;
            batt_low_q  <= batt_low_d;
            batt_cnt_q  <= batt_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign norm_mode = norm_mode_q;
    assign ovr_spd   = ovr_spd_q;
    assign batt_low  = batt_low_q;

endmodule
`default_nettype wire
